// File: rtl/rsa_pkg.sv
// -----------------------------------------------------------------------------
// rsa_pkg
//
// Shared definitions for the RSA decryption control path:
//   - default widths of the multiplier datapath, modulus and exponent
//   - the operation code driven to the shared Montgomery multiplier
//   - the state enumeration of the square-and-multiply sequencer
// -----------------------------------------------------------------------------
package rsa_pkg;

  localparam int DEF_DATA_WIDTH  = 32;
  localparam int DEF_DATA_LENGTH = 1024;
  localparam int DEF_EXP_WIDTH   = 1024;

  // Operation for one Montgomery multiply (operand pair and destination).
  typedef enum logic [1:0] {
    OP_TOMONT = 2'd0,  // XM  <- C   * T   (ciphertext into Montgomery domain)
    OP_SQR    = 2'd1,  // ACC <- ACC * ACC
    OP_MUL    = 2'd2,  // ACC <- ACC * XM
    OP_FROM   = 2'd3   // ACC <- ACC * 1   (leave Montgomery domain)
  } mm_op_e;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_PRE,
    ST_PRE_W,
    ST_TOMONT,
    ST_TOMONT_W,
    ST_SCAN,
    ST_SQR,
    ST_SQR_W,
    ST_MUL,
    ST_MUL_W,
    ST_NEXT,
    ST_FROM,
    ST_FROM_W
  } state_e;

endpackage

// File: rtl/modexp_sequencer.sv
// -----------------------------------------------------------------------------
// modexp_sequencer
//
// Controller for the RSA decryption datapath. Computes M = C^d mod n by
// left-to-right square-and-multiply in the Montgomery domain. It launches the
// precomputation unit once, converts C into the Montgomery domain, preloads
// the accumulator with R mod n, walks the exponent MSB first and finally
// converts the accumulator back out. All 1024-bit operands live in the
// multiplier wrapper; this block only holds the exponent and a bit index.
//
// Ports:
//   clk         in   clock, all logic on the rising edge
//   rst         in   synchronous, active-high reset
//   start       in   begin a decryption (sampled only while idle)
//   d           in   private exponent, captured when start is accepted
//   pre_start   out  one-cycle pulse launching the precomputation unit
//   pre_done    in   precomputation complete (pulse or level)
//   acc_load_r  out  one-cycle pulse: ACC <- R mod n
//   mm_start    out  one-cycle pulse launching one Montgomery multiply
//   mm_op       out  operation of the launched multiply, held until mm_done
//   mm_done     in   one-cycle pulse: multiply result written
//   busy        out  high from accepted start until done
//   done        out  one-cycle pulse: ACC holds the plaintext
// -----------------------------------------------------------------------------
module modexp_sequencer
  import rsa_pkg::*;
#(
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int DATA_LENGTH = DEF_DATA_LENGTH,
  parameter int EXP_WIDTH   = DEF_EXP_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [EXP_WIDTH-1:0] d,
  output logic                 pre_start,
  input  logic                 pre_done,
  output logic                 acc_load_r,
  output logic                 mm_start,
  output logic [1:0]           mm_op,
  input  logic                 mm_done,
  output logic                 busy,
  output logic                 done
);

  localparam int IDX_W = (EXP_WIDTH > 1) ? $clog2(EXP_WIDTH) : 1;
  localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(EXP_WIDTH - 1);

  // The datapath widths only matter to the multiplier wrapper; an illegal
  // pairing is left as an empty, named scope so it stands out in elaboration.
  if (DATA_WIDTH < 1 || DATA_LENGTH < DATA_WIDTH) begin : g_bad_datapath_cfg
  end

  state_e                 state_q;
  logic [IDX_W-1:0]       idx_q;
  logic [EXP_WIDTH-1:0]   d_q;
  logic                   pre_start_q;
  logic                   acc_load_r_q;
  logic                   mm_start_q;
  mm_op_e                 mm_op_q;
  logic                   busy_q;
  logic                   done_q;

  logic                   cur_bit;
  logic                   idx_at_zero;

  assign cur_bit     = d_q[idx_q];
  assign idx_at_zero = (idx_q == '0);

  // ---------------------------------------------------------------------------
  // Sequencer. All outputs are registered, so every pulse appears in the
  // first cycle of the state named after it (e.g. mm_start is high while the
  // FSM sits in ST_SQR). A mm_done seen in that launch cycle is therefore
  // ignored simply because only the *_W states look at it.
  // ---------------------------------------------------------------------------
  // NOTE: state updates use non-blocking assignments so every branch reads
  // the pre-edge values of idx_q/d_q; a blocking idx decrement would make
  // the bit test in the same branch see the new index.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      idx_q        <= '0;
      d_q          <= '0;
      pre_start_q  <= 1'b0;
      acc_load_r_q <= 1'b0;
      mm_start_q   <= 1'b0;
      mm_op_q      <= OP_TOMONT;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      // Pulses default low; only the transition that launches them sets them.
      pre_start_q  <= 1'b0;
      acc_load_r_q <= 1'b0;
      mm_start_q   <= 1'b0;
      done_q       <= 1'b0;

      case (state_q)
        ST_IDLE: begin
          if (start) begin
            d_q         <= d;
            idx_q       <= IDX_TOP;
            busy_q      <= 1'b1;
            pre_start_q <= 1'b1;
            state_q     <= ST_PRE;
          end
        end

        ST_PRE: state_q <= ST_PRE_W;

        ST_PRE_W: begin
          if (pre_done) begin
            mm_start_q <= 1'b1;
            mm_op_q    <= OP_TOMONT;
            state_q    <= ST_TOMONT;
          end
        end

        ST_TOMONT: state_q <= ST_TOMONT_W;

        ST_TOMONT_W: begin
          if (mm_done) begin
            acc_load_r_q <= 1'b1;
            state_q      <= ST_SCAN;
          end
        end

        // Leading zeros of d cost one cycle each and no multiplies: squaring
        // the Montgomery form of 1 would leave ACC unchanged anyway.
        ST_SCAN: begin
          if (cur_bit) begin
            mm_start_q <= 1'b1;
            mm_op_q    <= OP_SQR;
            state_q    <= ST_SQR;
          end else if (idx_at_zero) begin
            mm_start_q <= 1'b1;
            mm_op_q    <= OP_FROM;
            state_q    <= ST_FROM;
          end else begin
            idx_q <= idx_q - 1'b1;
          end
        end

        ST_SQR: state_q <= ST_SQR_W;

        ST_SQR_W: begin
          if (mm_done) begin
            if (cur_bit) begin
              mm_start_q <= 1'b1;
              mm_op_q    <= OP_MUL;
              state_q    <= ST_MUL;
            end else begin
              state_q <= ST_NEXT;
            end
          end
        end

        ST_MUL: state_q <= ST_MUL_W;

        ST_MUL_W: begin
          if (mm_done) state_q <= ST_NEXT;
        end

        // idx only moves down from here when there is another bit to do, so
        // it stops at 0 instead of wrapping to the top of the exponent.
        ST_NEXT: begin
          mm_start_q <= 1'b1;
          if (idx_at_zero) begin
            mm_op_q <= OP_FROM;
            state_q <= ST_FROM;
          end else begin
            idx_q   <= idx_q - 1'b1;
            mm_op_q <= OP_SQR;
            state_q <= ST_SQR;
          end
        end

        ST_FROM: state_q <= ST_FROM_W;

        ST_FROM_W: begin
          if (mm_done) begin
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign pre_start  = pre_start_q;
  assign acc_load_r = acc_load_r_q;
  assign mm_start   = mm_start_q;
  assign mm_op      = mm_op_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_modexp_sequencer.sv
// -----------------------------------------------------------------------------
// tb_modexp_sequencer
//
// Bench for modexp_sequencer. The reference is an event-level model: from the
// captured exponent it derives the list of multiplies (square-and-multiply
// from the first 1 bit) and the number of SCAN cycles, and from the times at
// which the bench itself raises pre_done/mm_done it schedules the cycle at
// which each output pulse must appear. Plain modular arithmetic over the same
// operation list pins the model against hand-computed results.
// -----------------------------------------------------------------------------
module tb_modexp_sequencer;
  import rsa_pkg::*;

  localparam int EW = 32;

  typedef logic [1:0] op_q_t[$];

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [EW-1:0] d = '0;
  logic          pre_done = 1'b0;
  logic          mm_done = 1'b0;
  logic          pre_start, acc_load_r, mm_start, busy, done;
  logic [1:0]    mm_op;

  always #5 clk = ~clk;

  modexp_sequencer #(
    .DATA_WIDTH (32),
    .DATA_LENGTH(1024),
    .EXP_WIDTH  (EW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .d         (d),
    .pre_start (pre_start),
    .pre_done  (pre_done),
    .acc_load_r(acc_load_r),
    .mm_start  (mm_start),
    .mm_op     (mm_op),
    .mm_done   (mm_done),
    .busy      (busy),
    .done      (done)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural reference
  // ---------------------------------------------------------------------------
  function automatic op_q_t build_ops(input logic [EW-1:0] dv);
    op_q_t q;
    bit    seen;
    seen = 1'b0;
    q.push_back(OP_TOMONT);
    for (int i = EW - 1; i >= 0; i--) begin
      if (dv[i]) seen = 1'b1;
      if (seen) begin
        q.push_back(OP_SQR);
        if (dv[i]) q.push_back(OP_MUL);
      end
    end
    q.push_back(OP_FROM);
    return q;
  endfunction

  // Cycles spent in SCAN: one per leading zero plus the cycle that finds the
  // first 1; for d=0 every bit position is visited once.
  function automatic int scan_cycles(input logic [EW-1:0] dv);
    for (int i = EW - 1; i >= 0; i--) if (dv[i]) return EW - i;
    return EW;
  endfunction

  // Result of the op list in ordinary modular arithmetic (Montgomery factors
  // cancel): ACC starts at 1, XM is C.
  function automatic longint plain_modexp(input op_q_t q, input longint c, input longint n);
    longint acc, xm;
    acc = 1;
    xm  = 0;
    foreach (q[i]) begin
      case (q[i])
        OP_TOMONT: xm  = c % n;
        OP_SQR:    acc = (acc * acc) % n;
        OP_MUL:    acc = (acc * xm) % n;
        default:   acc = acc;
      endcase
    end
    return acc;
  endfunction

  // Model state, describing the cycle the next compare will look at.
  bit         m_busy = 1'b0;
  int         t_pre = -1, t_mm = -1, t_acc = -1, t_done = -1;
  bit         pre_wait = 1'b0;
  int         pre_from = 0;
  bit         op_active = 1'b0;
  int         op_from = 0;
  logic [1:0] cur_op = 2'd0;
  bit         op_fresh = 1'b1;
  op_q_t      ops_q;
  int         scan_len = 0;

  bit         run_finished = 1'b0;
  int         run_mm_cnt = 0;
  int         run_done_cnt = 0;

  int         resp_pre = -1;
  int         resp_mm = -1;

  task automatic issue(input int t);
    cur_op    = ops_q.pop_front();
    t_mm      = t;
    op_from   = t;
    op_active = 1'b1;
    op_fresh  = 1'b0;
  endtask

  task automatic model_step(input bit st, input logic [EW-1:0] dv, input bit rs,
                            input bit pd, input bit md);
    if (rs) begin
      m_busy = 1'b0;
      t_pre = -1; t_mm = -1; t_acc = -1; t_done = -1;
      pre_wait  = 1'b0;
      op_active = 1'b0;
      op_fresh  = 1'b1;
      ops_q.delete();
    end else if (!m_busy) begin
      if (st) begin
        m_busy   = 1'b1;
        ops_q    = build_ops(dv);
        scan_len = scan_cycles(dv);
        t_pre    = cyc + 1;
        pre_wait = 1'b1;
        pre_from = cyc + 2;
      end
    end else if (pre_wait && cyc >= pre_from && pd) begin
      pre_wait = 1'b0;
      issue(cyc + 1);
    end else if (op_active && cyc > op_from && md) begin
      case (cur_op)
        OP_TOMONT: begin
          t_acc = cyc + 1;
          issue(cyc + 1 + scan_len);
        end
        OP_SQR: issue((ops_q[0] == OP_MUL) ? cyc + 1 : cyc + 2);
        OP_MUL: issue(cyc + 2);
        default: begin
          op_active    = 1'b0;
          t_done       = cyc + 1;
          m_busy       = 1'b0;
          run_finished = 1'b1;
        end
      endcase
    end
  endtask

  // One clock cycle: compare outputs, drive inputs, advance the model.
  task automatic tick(input bit st, input logic [EW-1:0] dv, input bit rs);
    bit pd, md;
    @(negedge clk);
    cyc++;
    check("busy",       64'(busy),       64'(m_busy));
    check("pre_start",  64'(pre_start),  64'(cyc == t_pre));
    check("acc_load_r", 64'(acc_load_r), 64'(cyc == t_acc));
    check("mm_start",   64'(mm_start),   64'(cyc == t_mm));
    check("done",       64'(done),       64'(cyc == t_done));
    if (op_active && cyc >= op_from) check("mm_op", 64'(mm_op), 64'(cur_op));
    else if (op_fresh) check("mm_op_reset", 64'(mm_op), 64'd0);
    if (mm_start === 1'b1) run_mm_cnt++;
    if (done === 1'b1) run_done_cnt++;

    start = st;
    d     = dv;
    rst   = rs;

    pd = 1'b0;
    if (resp_pre == 0) begin pd = 1'b1; resp_pre = -1; end
    else if (resp_pre > 0) resp_pre--;
    if (!pd && resp_pre < 0 && !(pre_wait && cyc >= pre_from) && $urandom_range(0, 7) == 0)
      pd = 1'b1;
    if (pre_start === 1'b1) resp_pre = int'($urandom_range(0, 20));

    md = 1'b0;
    if (resp_mm == 0) begin md = 1'b1; resp_mm = -1; end
    else if (resp_mm > 0) resp_mm--;
    if (!md && resp_mm < 0 && !(op_active && cyc > op_from) && $urandom_range(0, 5) == 0)
      md = 1'b1;
    if (mm_start === 1'b1) resp_mm = int'($urandom_range(0, 50));

    if (rs) begin
      resp_pre = -1;
      resp_mm  = -1;
    end
    pre_done = pd;
    mm_done  = md;

    model_step(st, dv, rs, pd, md);
  endtask

  task automatic run(input logic [EW-1:0] dv, input bit rst_in_mul);
    op_q_t q;
    int    n_ops, budget;
    bit    rst_hit;
    q            = build_ops(dv);
    n_ops        = q.size();
    budget       = n_ops * 60 + EW + 100;
    rst_hit      = 1'b0;
    run_mm_cnt   = 0;
    run_done_cnt = 0;
    run_finished = 1'b0;
    tick(1'b1, dv, 1'b0);
    for (int i = 0; i < budget && !run_finished; i++) begin
      if (rst_in_mul && op_active && cur_op == OP_MUL && cyc + 1 > op_from) begin
        tick(1'b0, $urandom, 1'b1);
        rst_hit = 1'b1;
        break;
      end
      tick($urandom_range(0, 9) == 0, $urandom, 1'b0);
    end
    if (rst_in_mul) begin
      check("rst_in_mul_reached", 64'(rst_hit), 64'd1);
      repeat (4) tick(1'b0, $urandom, 1'b0);
      check("done_after_rst", 64'(run_done_cnt), 64'd0);
    end else begin
      check("run_completed", 64'(run_finished), 64'd1);
      if (run_finished) begin
        tick(1'b0, $urandom, 1'b0);  // the done cycle
        check("done_count", 64'(run_done_cnt), 64'd1);
        check("mm_start_count", 64'(run_mm_cnt), 64'(n_ops));
      end else begin
        tick(1'b0, '0, 1'b1);
      end
    end
    repeat ($urandom_range(0, 3)) tick(1'b0, $urandom, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: bench did not finish by cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    op_q_t      q;
    logic [1:0] exp_b[9] = '{2'd0, 2'd1, 2'd2, 2'd1, 2'd1, 2'd2, 2'd1, 2'd2, 2'd3};
    logic [EW-1:0] dv;

    // Hand-computed expectations that pin the reference model.
    q = build_ops('0);
    check("pin_d0_len", 64'(q.size()), 64'd2);
    check("pin_d0_first", 64'(q[0]), 64'd0);
    check("pin_d0_last", 64'(q[1]), 64'd3);
    check("pin_d0_scan", 64'(scan_cycles('0)), 64'(EW));
    q = build_ops(EW'(1));
    check("pin_d1_len", 64'(q.size()), 64'd4);
    check("pin_d1_result", 64'(plain_modexp(q, 5, 221)), 64'd5);
    q = build_ops(EW'(11));
    check("pin_dB_len", 64'(q.size()), 64'd9);
    foreach (exp_b[i]) check("pin_dB_op", 64'(q[i]), 64'(exp_b[i]));
    check("pin_dB_result", 64'(plain_modexp(q, 2, 221)), 64'd59);
    check("pin_dB_scan", 64'(scan_cycles(EW'(11))), 64'(EW - 4 + 1));
    q = build_ops('1);
    check("pin_ones_len", 64'(q.size()), 64'(2 * EW + 2));

    repeat (3) tick(1'b0, '0, 1'b1);
    tick(1'b0, '0, 1'b0);

    run('0, 1'b0);
    run(EW'(1), 1'b0);
    run(EW'(11), 1'b0);
    run('1, 1'b0);
    run(EW'(1), 1'b1);
    run(EW'(1), 1'b0);
    for (int i = 0; i < 12; i++) begin
      dv = $urandom;
      dv = dv >> $urandom_range(0, EW - 1);
      run(dv, 1'b0);
    end
    repeat (3) tick(1'b0, '0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/modexp_sequencer.md
# modexp_sequencer

Top-level controller for the RSA decryption datapath; computes M = C^d mod n by square-and-multiply in the Montgomery domain. It sequences the precomputation unit (n0', R mod n, T = R² mod n) and a shared Montgomery multiplier. It drives start pulses, operand/destination opcodes and an accumulator preload. It owns no 1024-bit datapath storage; the operand registers live in the multiplier wrapper.

## Interface
Parameters:
- DATA_WIDTH, 32, word width of the multiplier datapath (informational, passed down)
- DATA_LENGTH, 1024, modulus/ciphertext length in bits
- EXP_WIDTH, 1024, exponent length in bits

Ports:
- clk  in  1  clock; all logic on posedge
- rst  in  1  synchronous, active-high reset
- start  in  1  begin a decryption; sampled only in IDLE
- d  in  EXP_WIDTH  private exponent; captured on accepted start
- pre_start  out  1  one-cycle pulse to precomputation unit
- pre_done  in  1  precomputation complete (pulse or level)
- acc_load_r  out  1  one-cycle pulse: ACC ← R mod n
- mm_start  out  1  one-cycle pulse: launch one Montgomery multiply
- mm_op  out  2  operation for the launched multiply, held stable until mm_done
- mm_done  in  1  one-cycle pulse: multiply result written
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse: ACC holds plaintext

## Operation
- mm_op encoding: 0 TOMONT (XM ← C·T), 1 SQR (ACC ← ACC·ACC), 2 MUL (ACC ← ACC·XM), 3 FROM (ACC ← ACC·1).
- States:
  - IDLE: on start, capture d into d_reg, idx ← EXP_WIDTH-1, go PRE.
  - PRE: pulse pre_start on entry, go PRE_W.
  - PRE_W: wait for pre_done, go TOMONT.
  - TOMONT: pulse mm_start with op 0, go TOMONT_W.
  - TOMONT_W: wait for mm_done; pulse acc_load_r; go SCAN.
  - SCAN: skips leading zeros, one bit per cycle. If d_reg[idx]=1, go SQR. Else if idx=0, go FROM. Else idx−1 and stay.
  - SQR: pulse mm_start with op 1, go SQR_W.
  - SQR_W: on mm_done, go MUL if d_reg[idx]=1, else go NEXT.
  - MUL: pulse mm_start with op 2, go MUL_W.
  - MUL_W: on mm_done, go NEXT.
  - NEXT: if idx=0, go FROM. Else idx−1, go SQR.
  - FROM: pulse mm_start with op 3, go FROM_W.
  - FROM_W: on mm_done, pulse done, go IDLE.
- idx is a $clog2(EXP_WIDTH)-bit down-counter with no wrap. At idx=0 the block always exits to FROM; it never decrements past 0.
- d=0: SCAN reaches idx 0 and goes directly to FROM. Result is R·1·R⁻¹ = 1.
- start while busy is ignored. d changes after capture have no effect.
- mm_done or pre_done outside the matching wait state is ignored.

## Timing
- Reset values: pre_start=0, acc_load_r=0, mm_start=0, mm_op=0, busy=0, done=0. State is IDLE, idx=0, d_reg=0.
- rst mid-operation: IDLE on the next edge, all outputs at reset values, no done pulse.
- pre_start is asserted in the cycle after start is sampled. busy rises in that same cycle.
- mm_start and mm_op are registered. mm_op is valid in the mm_start cycle and held until mm_done is sampled.
- mm_done is accepted no earlier than the cycle after mm_start. A mm_done in the same cycle as mm_start is ignored.
- acc_load_r is asserted the cycle after mm_done of TOMONT. SCAN begins the same cycle.
- Per exponent bit after the first 1: SQR costs 2 + L_mm cycles; a 1 bit adds another 2 + L_mm. NEXT adds 1 cycle.
- done is asserted the cycle after FROM's mm_done. busy falls in the same cycle. A new start is accepted the following cycle.

## Structure
- Shared package rsa_pkg holds:
  - DATA_WIDTH, DATA_LENGTH and EXP_WIDTH defaults;
  - the mm_op encoding (OP_TOMONT, OP_SQR, OP_MUL, OP_FROM);
  - the state enumeration.
- No sub-module is required. The FSM, idx counter and d_reg fit in one module.

## Test plan
- d=0 → op sequence TOMONT, FROM; one acc_load_r; done once; 2 mm_start pulses.
- d=1 → TOMONT, SQR, MUL, FROM; with C=5, n=221 the bench model gives M=5.
- d=0b1011 (0xB) → TOMONT, SQR, MUL, SQR, SQR, MUL, SQR, MUL, FROM. SCAN spends EXP_WIDTH−4 skip cycles. With C=2, n=221, M=2¹¹ mod 221=59.
- d = all ones → 2·EXP_WIDTH+2 mm_start pulses; idx never wraps; done once.
- mm_done delayed 0–50 random cycles; spurious mm_done/pre_done in IDLE/SCAN → sequence unchanged, no extra transitions.
- start pulsed while busy ignored. rst asserted in MUL_W → busy=0 next cycle, no done. A following start with d=1 completes normally.
